// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, response-pipeline entries
// and the width helper used to size address/index fields.
package sram_port_arbiter_pkg;

    // Widest requester index a pipeline entry can carry (up to 256 requesters).
    localparam int unsigned RspIdxMaxWidth = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic                      valid;
        logic [RspIdxMaxWidth-1:0] idx;
        logic                      we;
    } rsp_entry_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rsp_pipe.sv
// Fixed-depth shift register that carries issued-access tags alongside the SRAM
// read latency so each response lines up with its read data.
module sram_rsp_pipe
    import sram_port_arbiter_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  rsp_entry_t entry_i,
    output rsp_entry_t entry_o
);

    rsp_entry_t r_stage [Latency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= entry_i;
            for (int i = 1; i < Latency; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign entry_o = r_stage[Latency-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin sharing of one single-port SRAM among NumReq requesters, with an
// optional zero-fill sweep after reset and latency-matched response routing.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned  NumReq    = 4,
    parameter int unsigned  NumWords  = 1024,
    parameter int unsigned  DataWidth = 64,
    parameter int unsigned  ByteWidth = 8,
    parameter int unsigned  Latency   = 1,
    parameter bit           ZeroInit  = 1'b1,
    localparam int unsigned AddrWidth = clog2_min1(NumWords),
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    localparam int unsigned IdxWidth  = clog2_min1(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0]                req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]   req_be_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    output logic [NumReq-1:0][DataWidth-1:0] rsp_rdata_o,
    output logic                             init_done_o,
    output logic                             sram_req_o,
    output logic                             sram_we_o,
    output logic [AddrWidth-1:0]             sram_addr_o,
    output logic [DataWidth-1:0]             sram_wdata_o,
    output logic [BeWidth-1:0]               sram_be_o,
    input  logic [DataWidth-1:0]             sram_rdata_i
);

    localparam arb_state_e           ResetState = ZeroInit ? INIT : RUN;
    localparam logic [AddrWidth-1:0] LastAddr   = AddrWidth'(NumWords - 1);
    localparam logic [IdxWidth-1:0]  LastIdx    = IdxWidth'(NumReq - 1);

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [AddrWidth-1:0] r_init_cnt;
    logic [AddrWidth-1:0] w_init_cnt_next;
    logic [IdxWidth-1:0]  r_rr;
    logic [IdxWidth-1:0]  w_rr_next;

    logic                 w_grant_vld;
    logic [IdxWidth-1:0]  w_grant_idx;
    logic [NumReq-1:0]    w_grant_oh;
    logic                 w_issue;

    logic                 w_sel_we;
    logic [AddrWidth-1:0] w_sel_addr;
    logic [DataWidth-1:0] w_sel_wdata;
    logic [BeWidth-1:0]   w_sel_be;

    rsp_entry_t           w_pipe_in;
    rsp_entry_t           w_pipe_out;
    logic                 w_unused_rsp_we;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ResetState;
            r_init_cnt <= '0;
            r_rr       <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_cnt <= w_init_cnt_next;
            r_rr       <= w_rr_next;
        end
    end

    // Two passes: lowest valid index at/after the pointer, else lowest below it.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_grant_oh  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!w_grant_vld && req_valid_i[i] && (i >= 32'(r_rr))) begin
                w_grant_vld   = 1'b1;
                w_grant_idx   = IdxWidth'(i);
                w_grant_oh[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!w_grant_vld && req_valid_i[i] && (i < 32'(r_rr))) begin
                w_grant_vld   = 1'b1;
                w_grant_idx   = IdxWidth'(i);
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (w_grant_oh[i]) begin
                w_sel_we    = req_we_i[i];
                w_sel_addr  = req_addr_i[i];
                w_sel_wdata = req_wdata_i[i];
                w_sel_be    = req_be_i[i];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_cnt_next = r_init_cnt;
        w_rr_next       = r_rr;
        w_issue         = 1'b0;
        req_ready_o     = '0;
        sram_req_o      = 1'b0;
        sram_we_o       = 1'b0;
        sram_addr_o     = '0;
        sram_wdata_o    = '0;
        sram_be_o       = '0;
        unique case (r_state)
            INIT: begin
                sram_req_o      = 1'b1;
                sram_we_o       = 1'b1;
                sram_addr_o     = r_init_cnt;
                sram_be_o       = '1;
                w_init_cnt_next = r_init_cnt + AddrWidth'(1);
                if (r_init_cnt == LastAddr) begin
                    w_state_next    = RUN;
                    w_init_cnt_next = '0;
                end
            end
            RUN: begin
                req_ready_o = w_grant_oh;
                if (w_grant_vld) begin
                    w_issue      = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_we_o    = w_sel_we;
                    sram_addr_o  = w_sel_addr;
                    sram_wdata_o = w_sel_wdata;
                    sram_be_o    = w_sel_be;
                    w_rr_next    = (w_grant_idx == LastIdx) ? '0 : w_grant_idx + IdxWidth'(1);
                end
            end
            default: w_state_next = ResetState;
        endcase
    end

    assign init_done_o = (r_state == RUN);

    // Init sweep writes never enter the pipeline, so they produce no responses.
    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.valid = w_issue;
        w_pipe_in.idx   = RspIdxMaxWidth'(w_grant_idx);
        w_pipe_in.we    = w_sel_we;
    end

    sram_rsp_pipe #(
        .Latency (Latency)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .entry_i (w_pipe_in),
        .entry_o (w_pipe_out)
    );

    always_comb begin
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (w_pipe_out.valid && (w_pipe_out.idx == RspIdxMaxWidth'(i))) begin
                rsp_valid_o[i] = 1'b1;
            end
        end
    end

    assign rsp_rdata_o     = {NumReq{sram_rdata_i}};
    assign w_unused_rsp_we = w_pipe_out.we;

endmodule
